df_window_gen: RTL and testbench

DF_WINDOW_GEN -- requirements
Module: df_window_gen

---
 rtl/df_window_gen.sv | 199 +++++++++++++++++++
 tb/tb_df_window_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/df_window_gen.sv
// df_window_gen: turns a stream of 16-bit samples into sliding windows of
// KSIZE taps, emitting one window every STRIDE accepted taps over a frame
// of SIG_LEN real samples. Windows go out on a valid/ready handshake.
// Optional feature: define DF_WIN_PAD_EN to surround each frame with
// (KSIZE-1)/2 zero samples on both sides.
module df_window_gen #(
  parameter int KSIZE   = 3,
  parameter int STRIDE  = 1,
  parameter int SIG_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [15:0]   x,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [16*KSIZE-1:0]  win,
  output logic                 win_valid,
  input  logic                 out_ready,
  output logic                 win_last,
  output logic                 frame_done
);

  localparam int W  = 16 * KSIZE;
  localparam int HW = 16 * (KSIZE - 1);
`ifdef DF_WIN_PAD_EN
  localparam int PAD = (KSIZE - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int FLEN = SIG_LEN + 2 * PAD;
  localparam int NWIN = (FLEN - KSIZE) / STRIDE + 1;

  localparam logic [12:0] SIG_LEN_C = 13'(SIG_LEN);
  localparam logic [12:0] NWIN_C    = 13'(NWIN);
  localparam logic [4:0]  K_C       = 5'(KSIZE);
  localparam logic [4:0]  KM1_C     = 5'(KSIZE - 1);
  localparam logic [4:0]  SM1_C     = 5'(STRIDE - 1);
  localparam logic [4:0]  PAD_C     = 5'(PAD);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

  state_t         state_q, state_d;
  // Only the KSIZE-1 older taps are stored; the incoming sample completes
  // the window, so the registered window is built from history plus it.
  logic [HW-1:0]  hist_q, hist_d;
  logic [W-1:0]   win_q, win_d;
  logic           win_valid_q, win_valid_d;
  logic           win_last_q, win_last_d;
  logic [12:0]    acc_cnt_q, acc_cnt_d;
  logic [12:0]    win_cnt_q, win_cnt_d;
  logic [4:0]     fill_cnt_q, fill_cnt_d;
  logic [4:0]     str_cnt_q, str_cnt_d;
  logic           last_seen_q, last_seen_d;
`ifdef DF_WIN_PAD_EN
  logic [4:0]     pad_cnt_q, pad_cnt_d;
`endif

  logic           stall;
  logic           in_ready_c;
  logic           accept;
  logic           final_hs;
  logic           shift;
  logic [15:0]    shift_val;
  logic           emit;
  logic [W-1:0]   new_win;

  assign stall      = win_valid_q && !out_ready;
  assign in_ready_c = ((state_q == FILL) || (state_q == RUN)) && !stall &&
                      (acc_cnt_q != SIG_LEN_C);
  assign accept     = in_valid && in_ready_c;
  assign final_hs   = win_valid_q && win_last_q && out_ready;

  // Next-state, tap shifting and window emission for the whole frame.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    acc_cnt_d   = acc_cnt_q;
    win_cnt_d   = win_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    str_cnt_d   = str_cnt_q;
    last_seen_d = last_seen_q;
`ifdef DF_WIN_PAD_EN
    pad_cnt_d   = pad_cnt_q;
`endif
    shift       = 1'b0;
    shift_val   = '0;
    emit        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FILL;
          hist_d      = '0;
          acc_cnt_d   = '0;
          win_cnt_d   = '0;
          fill_cnt_d  = PAD_C;
          str_cnt_d   = '0;
          last_seen_d = 1'b0;
`ifdef DF_WIN_PAD_EN
          pad_cnt_d   = '0;
`endif
        end
      end
      FILL, RUN: begin
        if (accept) begin
          shift     = 1'b1;
          shift_val = x;
          acc_cnt_d = acc_cnt_q + 13'd1;
          if ((state_q == FILL) && (fill_cnt_q == KM1_C)) state_d = RUN;
        end
`ifdef DF_WIN_PAD_EN
        if (accept && (acc_cnt_q == SIG_LEN_C - 13'd1)) state_d = FLUSH;
`else
        if ((acc_cnt_q == SIG_LEN_C) && (final_hs || last_seen_q)) state_d = DONE;
`endif
      end
`ifdef DF_WIN_PAD_EN
      FLUSH: begin
        if (!stall && (pad_cnt_q != PAD_C)) begin
          shift     = 1'b1;
          shift_val = '0;
          pad_cnt_d = pad_cnt_q + 5'd1;
        end
        if ((pad_cnt_q == PAD_C) && (final_hs || last_seen_q)) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    new_win = {shift_val, hist_q};

    if (shift) begin
      hist_d = new_win[W-1:16];
      if (fill_cnt_q != K_C) fill_cnt_d = fill_cnt_q + 5'd1;
      if ((win_cnt_q != NWIN_C) &&
          ((fill_cnt_q == KM1_C) || ((fill_cnt_q == K_C) && (str_cnt_q == SM1_C))))
        emit = 1'b1;
      if (fill_cnt_q == K_C) str_cnt_d = emit ? 5'd0 : str_cnt_q + 5'd1;
    end

    if (win_valid_q && out_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
    if (final_hs) last_seen_d = 1'b1;

    if (emit) begin
      win_d       = new_win;
      win_valid_d = 1'b1;
      win_last_d  = (win_cnt_q == NWIN_C - 13'd1);
      win_cnt_d   = win_cnt_q + 13'd1;
    end
  end

  // State, taps, counters and registered window output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hist_q      <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      acc_cnt_q   <= '0;
      win_cnt_q   <= '0;
      fill_cnt_q  <= '0;
      str_cnt_q   <= '0;
      last_seen_q <= 1'b0;
`ifdef DF_WIN_PAD_EN
      pad_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      acc_cnt_q   <= acc_cnt_d;
      win_cnt_q   <= win_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      str_cnt_q   <= str_cnt_d;
      last_seen_q <= last_seen_d;
`ifdef DF_WIN_PAD_EN
      pad_cnt_q   <= pad_cnt_d;
`endif
    end
  end

  assign in_ready   = in_ready_c;
  assign win        = win_q;
  assign win_valid  = win_valid_q;
  assign win_last   = win_last_q;
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_df_window_gen.sv
// tb_df_window_gen: directed checks of df_window_gen on three instances
// (K=3/S=1/L=8, K=3/S=2/L=8, K=3/S=1/L=4). The padded build only runs the
// L=4 frame, whose expected windows include the zero padding.
module tb_df_window_gen;

  logic        clk;
  logic        rst;
  logic        start_s     [3];
  logic        in_valid_s  [3];
  logic        out_ready_s [3];
  logic [15:0] x_s         [3];
  logic        in_ready_s  [3];
  logic        win_valid_s [3];
  logic        win_last_s  [3];
  logic        frame_done_s[3];
  logic [47:0] win_s       [3];

  int passCount  = 0;
  int totalCount = 0;

  logic [47:0] gotWin[$];
  logic        gotLast[$];
  int          gotCyc[$];
  int          doneCyc;
  int          accCount;

  df_window_gen #(.KSIZE(3), .STRIDE(1), .SIG_LEN(8)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .x(x_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .win(win_s[0]), .win_valid(win_valid_s[0]),
    .out_ready(out_ready_s[0]), .win_last(win_last_s[0]), .frame_done(frame_done_s[0]));

  df_window_gen #(.KSIZE(3), .STRIDE(2), .SIG_LEN(8)) u_dut_s2 (
    .clk(clk), .rst(rst), .start(start_s[1]), .x(x_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .win(win_s[1]), .win_valid(win_valid_s[1]),
    .out_ready(out_ready_s[1]), .win_last(win_last_s[1]), .frame_done(frame_done_s[1]));

  df_window_gen #(.KSIZE(3), .STRIDE(1), .SIG_LEN(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .start(start_s[2]), .x(x_s[2]), .in_valid(in_valid_s[2]),
    .in_ready(in_ready_s[2]), .win(win_s[2]), .win_valid(win_valid_s[2]),
    .out_ready(out_ready_s[2]), .win_last(win_last_s[2]), .frame_done(frame_done_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs three taps, oldest first, into the window layout (oldest in low bits).
  function automatic logic [47:0] mkWin(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
    return {c, b, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [47:0] observed,
                             input logic [47:0] expected);
    totalCount = totalCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Opens a frame on instance idx and streams samples, recording every
  // window taken by the handshake. Optionally stalls out_ready for
  // stallCycles cycles once stallWin appears, stops early after stopAfter
  // accepted samples, and pulses start again at cycle midStartAt.
  task automatic applyStimulus(input int idx, input logic [15:0] samples[$],
                               input int stopAfter, input logic [47:0] stallWin,
                               input int stallCycles, input int midStartAt);
    int n;
    int stallLeft;
    bit stallActive;
    bit accepted;
    gotWin.delete();
    gotLast.delete();
    gotCyc.delete();
    doneCyc     = -1;
    n           = 0;
    stallLeft   = stallCycles;
    stallActive = 1'b0;
    start_s[idx] = 1'b1;
    @(posedge clk); #1;
    start_s[idx] = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (n >= stopAfter) break;
      in_valid_s[idx]  = (n < samples.size());
      x_s[idx]         = (n < samples.size()) ? samples[n] : 16'hDEAD;
      out_ready_s[idx] = 1'b1;
      if (stallLeft > 0 && (stallActive || (win_valid_s[idx] && win_s[idx] === stallWin))) begin
        stallActive      = 1'b1;
        out_ready_s[idx] = 1'b0;
        stallLeft        = stallLeft - 1;
      end
      #1;
      if (!out_ready_s[idx]) begin
        checkOutput($sformatf("stall_win_held_c%0d", cyc), win_s[idx], stallWin);
        checkOutput($sformatf("stall_valid_c%0d", cyc), 48'(win_valid_s[idx]), 48'd1);
        checkOutput($sformatf("stall_in_ready_c%0d", cyc), 48'(in_ready_s[idx]), 48'd0);
      end
      if (win_valid_s[idx] && out_ready_s[idx]) begin
        gotWin.push_back(win_s[idx]);
        gotLast.push_back(win_last_s[idx]);
        gotCyc.push_back(cyc);
      end
      if (frame_done_s[idx]) begin
        doneCyc = cyc;
        break;
      end
      accepted = in_valid_s[idx] && in_ready_s[idx];
      if (cyc == midStartAt) start_s[idx] = 1'b1;
      @(posedge clk); #1;
      start_s[idx] = 1'b0;
      if (accepted) n = n + 1;
    end
    in_valid_s[idx]  = 1'b0;
    out_ready_s[idx] = 1'b1;
    accCount = n;
  endtask

  task automatic checkFrame(input string tag, input logic [47:0] exp[$], input int expAcc,
                            input bit checkTiming);
    int lastCyc;
    checkOutput({tag, "_count"}, 48'(gotWin.size()), 48'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      checkOutput($sformatf("%s_win%0d", tag, k),
                  (k < gotWin.size()) ? gotWin[k] : 48'hx, exp[k]);
      checkOutput($sformatf("%s_last%0d", tag, k),
                  (k < gotLast.size()) ? 48'(gotLast[k]) : 48'hx,
                  (k == exp.size() - 1) ? 48'd1 : 48'd0);
    end
    checkOutput({tag, "_accepted"}, 48'(accCount), 48'(expAcc));
    checkOutput({tag, "_done_seen"}, 48'(doneCyc >= 0), 48'd1);
    if (checkTiming) begin
      lastCyc = (gotCyc.size() > 0) ? gotCyc[gotCyc.size() - 1] : -100;
      checkOutput({tag, "_done_delay"}, 48'(doneCyc - lastCyc), 48'd1);
    end
  endtask

  // One cycle after frame_done the block is back in IDLE.
  task automatic checkIdle(input int idx, input string tag);
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse_end"}, 48'(frame_done_s[idx]), 48'd0);
    checkOutput({tag, "_idle_in_ready"}, 48'(in_ready_s[idx]), 48'd0);
  endtask

  initial begin
    logic [15:0] s18[$];
    logic [15:0] sExt[$];
    logic [15:0] s5678[$];
    logic [47:0] exp[$];

    for (int i = 0; i < 3; i++) begin
      start_s[i]     = 1'b0;
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b1;
      x_s[i]         = 16'd0;
    end
    for (int i = 1; i <= 8; i++) s18.push_back(16'(i));
    sExt  = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    s5678 = '{16'd5, 16'd6, 16'd7, 16'd8};

    rst = 1'b0;
    #12;
    checkOutput("rst_win", win_s[0], 48'd0);
    checkOutput("rst_win_valid", 48'(win_valid_s[0]), 48'd0);
    checkOutput("rst_win_last", 48'(win_last_s[0]), 48'd0);
    checkOutput("rst_frame_done", 48'(frame_done_s[0]), 48'd0);
    checkOutput("rst_in_ready", 48'(in_ready_s[0]), 48'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

`ifdef DF_WIN_PAD_EN
    $display("[TB] padded frame K=3 L=4");
    applyStimulus(2, s5678, 1000, 48'd0, 0, -1);
    exp = '{mkWin(16'd0, 16'd5, 16'd6), mkWin(16'd5, 16'd6, 16'd7),
            mkWin(16'd6, 16'd7, 16'd8), mkWin(16'd7, 16'd8, 16'd0)};
    checkFrame("pad_l4", exp, 4, 1'b1);
    checkIdle(2, "pad_l4");
`else
    $display("[TB] K=3 S=1 L=8 back-to-back");
    applyStimulus(0, s18, 1000, 48'd0, 0, -1);
    exp.delete();
    for (int k = 0; k < 6; k++) exp.push_back(mkWin(16'(k + 1), 16'(k + 2), 16'(k + 3)));
    checkFrame("s1", exp, 8, 1'b1);
    checkIdle(0, "s1");

    $display("[TB] K=3 S=1 L=8 with downstream stall on (2,3,4)");
    applyStimulus(0, s18, 1000, mkWin(16'd2, 16'd3, 16'd4), 4, -1);
    checkFrame("stall", exp, 8, 1'b1);
    checkIdle(0, "stall");

    $display("[TB] K=3 S=2 L=8");
    applyStimulus(1, s18, 1000, 48'd0, 0, -1);
    exp = '{mkWin(16'd1, 16'd2, 16'd3), mkWin(16'd3, 16'd4, 16'd5),
            mkWin(16'd5, 16'd6, 16'd7)};
    checkFrame("s2", exp, 8, 1'b0);
    checkIdle(1, "s2");

    $display("[TB] extreme sample values");
    applyStimulus(0, sExt, 1000, 48'd0, 0, -1);
    checkOutput("ext_count", 48'(gotWin.size()), 48'd6);
    checkOutput("ext_win0", (gotWin.size() > 0) ? gotWin[0] : 48'hx, 48'hFFFF_7FFF_8000);
    checkOutput("ext_win1", (gotWin.size() > 1) ? gotWin[1] : 48'hx, 48'h0001_FFFF_7FFF);
    checkIdle(0, "ext");

    $display("[TB] K=3 S=1 L=4 unpadded");
    applyStimulus(2, s5678, 1000, 48'd0, 0, -1);
    exp = '{mkWin(16'd5, 16'd6, 16'd7), mkWin(16'd6, 16'd7, 16'd8)};
    checkFrame("l4", exp, 4, 1'b1);
    checkIdle(2, "l4");

    $display("[TB] reset in the middle of a frame");
    applyStimulus(0, s18, 5, 48'd0, 0, -1);
    checkOutput("mid_accepted", 48'(accCount), 48'd5);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_win", win_s[0], 48'd0);
    checkOutput("mid_rst_win_valid", 48'(win_valid_s[0]), 48'd0);
    checkOutput("mid_rst_win_last", 48'(win_last_s[0]), 48'd0);
    checkOutput("mid_rst_frame_done", 48'(frame_done_s[0]), 48'd0);
    checkOutput("mid_rst_in_ready", 48'(in_ready_s[0]), 48'd0);
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    in_valid_s[0] = 1'b1;
    x_s[0]        = 16'd9;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("post_rst_no_frame_c%0d", c), 48'(in_ready_s[0]), 48'd0);
    end
    in_valid_s[0] = 1'b0;
    applyStimulus(0, s18, 1000, 48'd0, 0, 4);
    exp.delete();
    for (int k = 0; k < 6; k++) exp.push_back(mkWin(16'(k + 1), 16'(k + 2), 16'(k + 3)));
    checkFrame("refr", exp, 8, 1'b1);
    checkIdle(0, "refr");
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
